echo_fifo_rep: RTL and testbench

- Parametrised successor of the single-entry echo block: accepts echo requests into a DEPTH-entry FIFO and replays each value on the echo indication interface.
- Adds per-request repeat count, optional incrementing replay mode, repeat index/last tagging and an occupancy output.
- Sits between the request portal and the indication proxy in loopback/echo test designs.

---
 rtl/echo_fifo_rep.sv | 134 +++++++++++++
 tb/tb_echo_fifo_rep.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/echo_fifo_rep.sv
// echo_fifo_rep
// Multi-entry echo block. Requests {value, count} are queued in a DEPTH-entry
// FIFO. The head entry is replayed count times on the echo indication
// interface, with each repeat tagged by its index and a last flag. When INCR
// is set, repeat k carries value+k. A zero-count entry is dropped in one cycle
// without producing an indication.
//
// Ports
//   CLK             : clock; all state changes on the rising edge
//   nRST            : asynchronous active-low reset
//   echoReq__ENA    : request strobe, honoured only when echoReq__RDY=1
//   echoReq_v       : echo value
//   echoReq_count   : number of indications to emit (0 = accept and discard)
//   echoReq__RDY    : FIFO not full and not in reset
//   ind_echo__ENA   : indication strobe
//   ind_echo_v      : indication value (0 when ENA=0)
//   ind_echo_idx    : repeat index (0 when ENA=0)
//   ind_echo_last   : final repeat of the head entry (0 when ENA=0)
//   ind_echo__RDY   : downstream accepts an indication this cycle
//   occupancy       : number of stored entries
module echo_fifo_rep #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = 4,
  parameter int INCR  = 0
) (
  input  logic                         CLK,
  input  logic                         nRST,
  input  logic                         echoReq__ENA,
  input  logic [WIDTH-1:0]             echoReq_v,
  input  logic [CNT_W-1:0]             echoReq_count,
  output logic                         echoReq__RDY,
  output logic                         ind_echo__ENA,
  output logic [WIDTH-1:0]             ind_echo_v,
  output logic [CNT_W-1:0]             ind_echo_idx,
  output logic                         ind_echo_last,
  input  logic                         ind_echo__RDY,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH+1);

  // Value carried by repeat number rep of an entry.
  function automatic logic [WIDTH-1:0] replay_value(input logic [WIDTH-1:0] v,
                                                    input logic [CNT_W-1:0] rep);
    logic [WIDTH-1:0] r;
    if (INCR != 0) r = v + WIDTH'(rep);
    else           r = v;
    return r;
  endfunction

  logic [WIDTH-1:0] mem_v_q [DEPTH];
  logic [CNT_W-1:0] mem_c_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic [CNT_W-1:0] rep_q, rep_d;

  logic             push, pop, head_vld, emit, is_last;
  logic [WIDTH-1:0] head_v;
  logic [CNT_W-1:0] head_c;

  assign head_vld = (occ_q != OCC_W'(0));
  assign head_v   = mem_v_q[rd_ptr_q];
  assign head_c   = mem_c_q[rd_ptr_q];

  // Gated with nRST so both strobes are low for the whole reset interval,
  // not only after the asynchronous clear has propagated through state.
  assign echoReq__RDY = nRST && (occ_q != OCC_W'(DEPTH));
  assign push         = echoReq__ENA && echoReq__RDY;

  assign is_last = (rep_q == head_c - CNT_W'(1));
  assign emit    = nRST && head_vld && (head_c != CNT_W'(0)) && ind_echo__RDY;

  // A zero-count head leaves in one cycle regardless of downstream readiness.
  assign pop = (nRST && head_vld && (head_c == CNT_W'(0))) || (emit && is_last);

  always_comb begin
    ind_echo__ENA = emit;
    ind_echo_v    = '0;
    ind_echo_idx  = '0;
    ind_echo_last = 1'b0;
    if (emit) begin
      ind_echo_v    = replay_value(head_v, rep_q);
      ind_echo_idx  = rep_q;
      ind_echo_last = is_last;
    end
  end

  assign occupancy = occ_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    rep_d    = rep_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
    if (emit) begin
      if (is_last) rep_d = '0;
      else         rep_d = rep_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      rep_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      rep_q    <= rep_d;
    end
  end

  // Storage is not reset; an entry is only read once occupancy covers it.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_v_q[wr_ptr_q] <= echoReq_v;
      mem_c_q[wr_ptr_q] <= echoReq_count;
    end
  end

endmodule

// File: tb/tb_echo_fifo_rep.sv
module tb_echo_fifo_rep;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int CNT_W = 4;
  localparam int INCR  = 1;
  localparam int OCC_W = $clog2(DEPTH+1);

  logic               CLK = 1'b0;
  logic               nRST;
  logic               req_ena;
  logic [WIDTH-1:0]   req_v;
  logic [CNT_W-1:0]   req_cnt;
  logic               req_rdy;
  logic               ind_ena;
  logic [WIDTH-1:0]   ind_v;
  logic [CNT_W-1:0]   ind_idx;
  logic               ind_last;
  logic               ind_rdy;
  logic [OCC_W-1:0]   occ;

  echo_fifo_rep #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W), .INCR(INCR)) dut (
    .CLK           (CLK),
    .nRST          (nRST),
    .echoReq__ENA  (req_ena),
    .echoReq_v     (req_v),
    .echoReq_count (req_cnt),
    .echoReq__RDY  (req_rdy),
    .ind_echo__ENA (ind_ena),
    .ind_echo_v    (ind_v),
    .ind_echo_idx  (ind_idx),
    .ind_echo_last (ind_last),
    .ind_echo__RDY (ind_rdy),
    .occupancy     (occ)
  );

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model: a queue of pending requests plus the repeat number of
  // the head entry.
  typedef struct {
    logic [WIDTH-1:0] v;
    int               cnt;
  } ent_t;

  ent_t m_q[$];
  int   m_rep;

  // Most recent observed outputs, for directed checks.
  logic             o_ena, o_last, o_rdy;
  logic [WIDTH-1:0] o_v;
  logic [CNT_W-1:0] o_idx;
  logic [OCC_W-1:0] o_occ;

  // One clock cycle: drive inputs after the falling edge, compare every output
  // against the model, then advance the model to the state after the next
  // rising edge.
  task automatic cycle(input logic ena, input logic [WIDTH-1:0] v,
                       input int cnt, input logic ird);
    logic             e_rdy, e_ena, e_last, hv;
    logic [WIDTH-1:0] e_v;
    int               e_idx;
    @(negedge CLK);
    req_ena = ena;
    req_v   = v;
    req_cnt = CNT_W'(cnt);
    ind_rdy = ird;
    #1;
    e_rdy  = (m_q.size() != DEPTH);
    hv     = (m_q.size() != 0);
    e_ena  = hv && (m_q[0].cnt != 0) && ird;
    e_v    = '0;
    e_idx  = 0;
    e_last = 1'b0;
    if (e_ena) begin
      e_v    = (INCR != 0) ? m_q[0].v + WIDTH'(m_rep) : m_q[0].v;
      e_idx  = m_rep;
      e_last = (m_rep == m_q[0].cnt - 1);
    end
    o_ena = ind_ena; o_v = ind_v; o_idx = ind_idx; o_last = ind_last;
    o_rdy = req_rdy; o_occ = occ;
    chk("req_rdy",  req_rdy,  e_rdy);
    chk("ind_ena",  ind_ena,  e_ena);
    chk("ind_v",    ind_v,    e_v);
    chk("ind_idx",  ind_idx,  e_idx);
    chk("ind_last", ind_last, e_last);
    chk("occupancy", occ,     m_q.size());
    // model state after the coming edge
    if (hv && m_q[0].cnt == 0) begin
      void'(m_q.pop_front());
    end else if (e_ena) begin
      if (e_last) begin
        void'(m_q.pop_front());
        m_rep = 0;
      end else begin
        m_rep++;
      end
    end
    if (ena && e_rdy) m_q.push_back('{v: v, cnt: cnt});
  endtask

  task automatic idle(input int n, input logic ird);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 0, ird);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    nRST = 1'b0;
    req_ena = 1'b0;
    m_q.delete();
    m_rep = 0;
    @(negedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  initial begin
    nRST    = 1'b0;
    req_ena = 1'b0;
    req_v   = '0;
    req_cnt = '0;
    ind_rdy = 1'b1;
    m_rep   = 0;
    #1;
    chk("rst_rdy", req_rdy, 0);
    chk("rst_ena", ind_ena, 0);
    chk("rst_occ", occ, 0);
    do_reset();

    // Single request, count 1: indication one cycle after acceptance.
    cycle(1'b1, 32'h12345678, 1, 1'b1);
    chk("t1_acc_ena", o_ena, 0);
    cycle(1'b0, '0, 0, 1'b1);
    chk("t1_ena",  o_ena, 1);
    chk("t1_v",    o_v, 32'h12345678);
    chk("t1_last", o_last, 1);
    chk("t1_occ",  o_occ, 1);
    cycle(1'b0, '0, 0, 1'b1);
    chk("t1_occ0", o_occ, 0);

    // Incrementing replay across the top of the value range.
    cycle(1'b1, 32'hFFFFFFFE, 3, 1'b1);
    cycle(1'b0, '0, 0, 1'b1);
    chk("t2_v0", o_v, 32'hFFFFFFFE); chk("t2_l0", o_last, 0);
    cycle(1'b0, '0, 0, 1'b1);
    chk("t2_v1", o_v, 32'hFFFFFFFF); chk("t2_i1", o_idx, 1);
    cycle(1'b0, '0, 0, 1'b1);
    chk("t2_v2", o_v, 32'h00000000); chk("t2_i2", o_idx, 2); chk("t2_l2", o_last, 1);
    idle(1, 1'b1);

    // Fill while downstream stalled; fifth request must be dropped.
    for (int i = 0; i < 5; i++) cycle(1'b1, 32'h100 + i, 1, 1'b0);
    cycle(1'b0, '0, 0, 1'b0);
    chk("t3_full_occ", o_occ, 4);
    chk("t3_full_rdy", o_rdy, 0);
    cycle(1'b0, '0, 0, 1'b1);
    chk("t3_first", o_v, 32'h100);
    cycle(1'b0, '0, 0, 1'b1);
    chk("t3_rdy_back", o_rdy, 1);
    idle(4, 1'b1);

    // Zero-count entry between two count-1 entries.
    cycle(1'b1, 32'd1, 1, 1'b1);
    cycle(1'b1, 32'd2, 0, 1'b1);
    cycle(1'b1, 32'd3, 1, 1'b1);
    idle(5, 1'b1);

    // Stall in the middle of a count-2 replay.
    cycle(1'b1, 32'hA0, 2, 1'b0);
    cycle(1'b0, '0, 0, 1'b1);
    chk("t5_i0", o_idx, 0);
    cycle(1'b0, '0, 0, 1'b0);
    chk("t5_stall", o_ena, 0);
    cycle(1'b0, '0, 0, 1'b1);
    chk("t5_i1", o_idx, 1); chk("t5_v1", o_v, 32'hA1);
    idle(2, 1'b1);

    // Asynchronous reset mid-replay.
    cycle(1'b1, 32'h55, 4, 1'b0);
    cycle(1'b1, 32'h66, 2, 1'b0);
    cycle(1'b1, 32'h77, 2, 1'b1);
    cycle(1'b0, '0, 0, 1'b1);
    chk("t6_pre_occ", o_occ, 3);
    #2;
    nRST = 1'b0;
    #1;
    chk("t6_ena", ind_ena, 0);
    chk("t6_rdy", req_rdy, 0);
    chk("t6_occ", occ, 0);
    m_q.delete();
    m_rep = 0;
    @(negedge CLK);
    nRST = 1'b1;
    idle(4, 1'b1);
    cycle(1'b1, 32'h99, 1, 1'b1);
    cycle(1'b0, '0, 0, 1'b1);
    chk("t6_new", o_v, 32'h99);
    idle(1, 1'b1);

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      int c;
      c = ($urandom_range(0, 9) == 0) ? 15 : int'($urandom_range(0, 3));
      cycle($urandom_range(0, 1) == 1, $urandom, c, $urandom_range(0, 3) != 0);
    end
    idle(80, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
